// File: rtl/rf_write_queue.sv
// ---------------------------------------------------------------------------
// rf_write_queue
//   Write-side feeder for the 32x32 register file. Collects writebacks from a
//   primary (WB stage) and a secondary (multi-cycle unit) producer into a small
//   in-order queue and issues at most one registered write per cycle. Also
//   reports pending-write hazards for two ID-stage source registers.
//
//   Optional feature macro: RF_WRITE_QUEUE_FWD_EN (adds fwd1_data/fwd2_data).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pri_valid/reg/data/ready primary write request handshake
//   sec_valid/reg/data/ready secondary write request handshake
//   RegWrite/WriteReg/WriteData registered register-file write port
//   chk_reg1/chk_reg2        ID-stage source registers to check
//   pend1/pend2              a write to chk_regN is queued or issuing
//   q_count/full/empty       queue occupancy status
//   fwd1_data/fwd2_data      youngest pending value for chk_regN (FWD_EN only)
// ---------------------------------------------------------------------------
module rf_write_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pri_valid,
   input  logic [ADDR_W-1:0]         pri_reg,
   input  logic [DATA_W-1:0]         pri_data,
   output logic                      pri_ready,
   input  logic                      sec_valid,
   input  logic [ADDR_W-1:0]         sec_reg,
   input  logic [DATA_W-1:0]         sec_data,
   output logic                      sec_ready,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WriteReg,
   output logic [DATA_W-1:0]         WriteData,
   input  logic [ADDR_W-1:0]         chk_reg1,
   input  logic [ADDR_W-1:0]         chk_reg2,
   output logic                      pend1,
   output logic                      pend2,
   output logic [$clog2(DEPTH):0]    q_count,
   output logic                      full,
   output logic                      empty
`ifdef RF_WRITE_QUEUE_FWD_EN
   ,
   output logic [DATA_W-1:0]         fwd1_data,
   output logic [DATA_W-1:0]         fwd2_data
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_reg  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_regwrite;
   logic [ADDR_W-1:0] r_writereg;
   logic [DATA_W-1:0] r_writedata;

   logic              w_pop;
   logic [CNT_W-1:0]  w_free;
   logic              w_pri_enq;
   logic              w_sec_enq;
   logic [PTR_W-1:0]  w_sec_idx;
   logic [CNT_W-1:0]  w_enq_cnt;
   logic [PTR_W-1:0]  w_idx;
   logic              w_pend1;
   logic              w_pend2;
`ifdef RF_WRITE_QUEUE_FWD_EN
   logic [DATA_W-1:0] w_fwd1;
   logic [DATA_W-1:0] w_fwd2;
`endif

   // The head is always drained, so a pop frees a slot in the same cycle.
   assign w_pop     = (r_count != '0);
   assign w_free    = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
   assign pri_ready = (w_free != '0);
   assign sec_ready = pri_valid ? (w_free >= CNT_W'(2)) : (w_free != '0);

   // Register 0 completes the handshake but is dropped.
   assign w_pri_enq = pri_valid && pri_ready && (pri_reg != '0);
   assign w_sec_enq = sec_valid && sec_ready && (sec_reg != '0);
   assign w_sec_idx = r_tail + PTR_W'(w_pri_enq);
   assign w_enq_cnt = CNT_W'(w_pri_enq) + CNT_W'(w_sec_enq);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_reg[i]  <= '0;
            r_data[i] <= '0;
         end
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_regwrite  <= 1'b0;
         r_writereg  <= '0;
         r_writedata <= '0;
      end else begin
         if (w_pri_enq) begin
            r_reg[r_tail]  <= pri_reg;
            r_data[r_tail] <= pri_data;
         end
         if (w_sec_enq) begin
            r_reg[w_sec_idx]  <= sec_reg;
            r_data[w_sec_idx] <= sec_data;
         end
         r_tail  <= r_tail + PTR_W'(w_enq_cnt);
         r_count <= r_count + w_enq_cnt - CNT_W'(w_pop);
         if (w_pop) begin
            r_regwrite  <= 1'b1;
            r_writereg  <= r_reg[r_head];
            r_writedata <= r_data[r_head];
            r_head      <= r_head + PTR_W'(1);
         end else begin
            r_regwrite  <= 1'b0;
         end
      end
   end

   // Hazard search over the issue register and the live queue entries, walked
   // oldest-first so the last match seen is the youngest pending value.
   always_comb begin
      w_idx   = '0;
      w_pend1 = r_regwrite && (r_writereg == chk_reg1);
      w_pend2 = r_regwrite && (r_writereg == chk_reg2);
`ifdef RF_WRITE_QUEUE_FWD_EN
      w_fwd1  = r_writedata;
      w_fwd2  = r_writedata;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_idx = r_head + PTR_W'(k);
         if (CNT_W'(k) < r_count) begin
            if (r_reg[w_idx] == chk_reg1) begin
               w_pend1 = 1'b1;
`ifdef RF_WRITE_QUEUE_FWD_EN
               w_fwd1  = r_data[w_idx];
`endif
            end
            if (r_reg[w_idx] == chk_reg2) begin
               w_pend2 = 1'b1;
`ifdef RF_WRITE_QUEUE_FWD_EN
               w_fwd2  = r_data[w_idx];
`endif
            end
         end
      end
   end

   assign pend1 = w_pend1 && (chk_reg1 != '0);
   assign pend2 = w_pend2 && (chk_reg2 != '0);
`ifdef RF_WRITE_QUEUE_FWD_EN
   assign fwd1_data = pend1 ? w_fwd1 : '0;
   assign fwd2_data = pend2 ? w_fwd2 : '0;
`endif

   assign RegWrite  = r_regwrite;
   assign WriteReg  = r_writereg;
   assign WriteData = r_writedata;
   assign q_count   = r_count;
   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);

endmodule

// File: tb/tb_rf_write_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_write_queue
//   Directed bench for rf_write_queue. The driver pushes each accepted,
//   non-zero-register request into a scoreboard; a monitor pops and compares
//   on every RegWrite pulse.
// ---------------------------------------------------------------------------
module tb_rf_write_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   pri_valid;
   logic [ADDR_W-1:0]      pri_reg;
   logic [DATA_W-1:0]      pri_data;
   logic                   pri_ready;
   logic                   sec_valid;
   logic [ADDR_W-1:0]      sec_reg;
   logic [DATA_W-1:0]      sec_data;
   logic                   sec_ready;
   logic                   RegWrite;
   logic [ADDR_W-1:0]      WriteReg;
   logic [DATA_W-1:0]      WriteData;
   logic [ADDR_W-1:0]      chk_reg1;
   logic [ADDR_W-1:0]      chk_reg2;
   logic                   pend1;
   logic                   pend2;
   logic [$clog2(DEPTH):0] q_count;
   logic                   full;
   logic                   empty;
`ifdef RF_WRITE_QUEUE_FWD_EN
   logic [DATA_W-1:0]      fwd1_data;
   logic [DATA_W-1:0]      fwd2_data;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] r;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;

   rf_write_queue #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pri_valid(pri_valid),
      .pri_reg  (pri_reg),
      .pri_data (pri_data),
      .pri_ready(pri_ready),
      .sec_valid(sec_valid),
      .sec_reg  (sec_reg),
      .sec_data (sec_data),
      .sec_ready(sec_ready),
      .RegWrite (RegWrite),
      .WriteReg (WriteReg),
      .WriteData(WriteData),
      .chk_reg1 (chk_reg1),
      .chk_reg2 (chk_reg2),
      .pend1    (pend1),
      .pend2    (pend2),
      .q_count  (q_count),
      .full     (full),
      .empty    (empty)
`ifdef RF_WRITE_QUEUE_FWD_EN
      ,
      .fwd1_data(fwd1_data),
      .fwd2_data(fwd2_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's requests after the negedge; the transfer happens on the
   // following posedge. Expected ready values are hand-computed by the caller.
   task automatic step(input logic pv, input logic [ADDR_W-1:0] pr, input logic [DATA_W-1:0] pd,
                       input logic sv, input logic [ADDR_W-1:0] sr, input logic [DATA_W-1:0] sd,
                       input logic epr, input logic esr);
      @(negedge clk);
      pri_valid = pv;
      pri_reg   = pr;
      pri_data  = pd;
      sec_valid = sv;
      sec_reg   = sr;
      sec_data  = sd;
      #1;
      if (pv) begin
         chk("pri_ready", pri_ready, epr);
         if (epr && pr != 0) sb.push_back(wr_t'{r: pr, d: pd});
      end
      if (sv) begin
         chk("sec_ready", sec_ready, esr);
         if (esr && sr != 0) sb.push_back(wr_t'{r: sr, d: sd});
      end
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: every issued write must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && RegWrite) begin
         wr_t e;
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                     WriteReg, WriteData);
         end else begin
            e = sb.pop_front();
            if (WriteReg !== e.r || WriteData !== e.d) begin
               n_errors++;
               $display("FAIL write_order: got reg %0d data %0h expected reg %0d data %0h",
                        WriteReg, WriteData, e.r, e.d);
            end
         end
      end
   end

   initial begin
      pri_valid = 1'b0; pri_reg = '0; pri_data = '0;
      sec_valid = 1'b0; sec_reg = '0; sec_data = '0;
      chk_reg1  = '0;   chk_reg2 = '0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_WriteReg", WriteReg, 0);
      chk("rst_WriteData", WriteData, 0);
      chk("rst_q_count", q_count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      idle();
      chk("post_rst_RegWrite", RegWrite, 0);
      chk("post_rst_q_count", q_count, 0);

      // Single write latency and hazard window
      chk_reg1 = 5'd5;
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      chk("single_RegWrite_k", RegWrite, 0);
      chk("single_q_count", q_count, 1);
      chk("single_pend1_queued", pend1, 1);
      chk("single_empty", empty, 0);
      idle();
      chk("single_RegWrite_k1", RegWrite, 1);
      chk("single_WriteReg", WriteReg, 5);
      chk("single_WriteData", WriteData, 32'hDEADBEEF);
      chk("single_pend1_issue", pend1, 1);
      chk("single_q_count_drained", q_count, 0);
      idle();
      chk("single_RegWrite_off", RegWrite, 0);
      chk("single_pend1_clear", pend1, 0);
      chk("single_WriteReg_hold", WriteReg, 5);

      // Dual accept, primary first
      chk_reg1 = 5'd3;
      chk_reg2 = 5'd4;
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b1);
      idle();
      chk("dual_q_count", q_count, 2);
      chk("dual_pend1", pend1, 1);
      chk("dual_pend2", pend2, 1);
      idle();
      chk("dual_first_reg", WriteReg, 3);
      chk("dual_first_data", WriteData, 32'h11);
      chk("dual_pend2_queued", pend2, 1);
      idle();
      chk("dual_second_reg", WriteReg, 4);
      chk("dual_second_data", WriteData, 32'h22);
      chk("dual_pend1_clear", pend1, 0);
      idle();
      chk("dual_RegWrite_off", RegWrite, 0);
      chk("dual_pend2_clear", pend2, 0);
      chk("dual_empty", empty, 1);

      // Back-pressure: fill to DEPTH at +1 per cycle, then sec refused once
      chk_reg1 = '0;
      chk_reg2 = '0;
      step(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 1'b1, 1'b1);
      step(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, 1'b1, 1'b1);
      chk("bp_q_count_2", q_count, 2);
      step(1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105, 1'b1, 1'b1);
      chk("bp_q_count_3", q_count, 3);
      step(1'b1, 5'd16, 32'h106, 1'b1, 5'd17, 32'h107, 1'b1, 1'b0);
      chk("bp_q_count_full", q_count, 4);
      chk("bp_full", full, 1);
      step(1'b0, '0, '0, 1'b1, 5'd17, 32'h107, 1'b0, 1'b1);
      chk("bp_q_count_held", q_count, 4);
      repeat (6) idle();
      chk("bp_drained", empty, 1);

      // Register 0 is accepted but dropped
      step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      chk("r0_q_count", q_count, 0);
      chk("r0_RegWrite", RegWrite, 0);
      chk("r0_pend1", pend1, 0);
      chk_reg2 = 5'd9;
      step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
      idle();
      chk("r0_sec_q_count", q_count, 1);
      chk("r0_sec_pend2", pend2, 1);
      idle();
      chk("r0_sec_WriteReg", WriteReg, 9);
      idle();
      chk_reg2 = '0;

`ifdef RF_WRITE_QUEUE_FWD_EN
      // Forwarding picks the youngest pending value
      chk_reg1 = 5'd7;
      step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 1'b1);
      idle();
      chk("fwd_pend1", pend1, 1);
      chk("fwd_data_both", fwd1_data, 32'hB);
      idle();
      chk("fwd_issue_A", WriteData, 32'hA);
      chk("fwd_data_queued_B", fwd1_data, 32'hB);
      idle();
      chk("fwd_data_issue_B", fwd1_data, 32'hB);
      idle();
      chk("fwd_pend1_clear", pend1, 0);
      chk("fwd_data_zero", fwd1_data, 0);
      chk_reg1 = '0;
`endif

      // Asynchronous reset mid-operation discards queued entries
      step(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201, 1'b1, 1'b1);
      step(1'b1, 5'd22, 32'h202, 1'b0, '0, '0, 1'b1, 1'b0);
      idle();
      chk("mid_RegWrite_before", RegWrite, 1);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_RegWrite", RegWrite, 0);
      chk("mid_rst_WriteReg", WriteReg, 0);
      chk("mid_rst_WriteData", WriteData, 0);
      chk("mid_rst_q_count", q_count, 0);
      chk("mid_rst_empty", empty, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      idle();
      chk("mid_post_RegWrite", RegWrite, 0);
      chk("mid_post_q_count", q_count, 0);
      repeat (3) idle();

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Write-side feeder for the pipeline's 32x32 register file.
- Collects register writebacks from two producers: the primary WB pipeline stage and a secondary multi-cycle source (load-miss return or mult/div unit).
- Buffers them in a small in-order queue and issues at most one write per cycle onto the register file's RegWrite/WriteReg/WriteData port.
- Also reports pending-write hazards to the ID stage.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, >= 2)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- pri_valid  in  1  primary (WB stage) write request
- pri_reg  in  ADDR_W  primary destination register
- pri_data  in  DATA_W  primary write data
- pri_ready  out  1  primary request accepted this cycle
- sec_valid  in  1  secondary (multi-cycle unit) write request
- sec_reg  in  ADDR_W  secondary destination register
- sec_data  in  DATA_W  secondary write data
- sec_ready  out  1  secondary request accepted this cycle
- RegWrite  out  1  register-file write enable (registered)
- WriteReg  out  ADDR_W  register-file write index (registered)
- WriteData  out  DATA_W  register-file write data (registered)
- chk_reg1  in  ADDR_W  ID-stage source register 1 to check
- chk_reg2  in  ADDR_W  ID-stage source register 2 to check
- pend1  out  1  chk_reg1 has a write in flight
- pend2  out  1  chk_reg2 has a write in flight
- q_count  out  $clog2(DEPTH)+1  current queue occupancy
- full  out  1  q_count == DEPTH
- empty  out  1  q_count == 0

Behaviour:
- Reset (async, rst=1): queue pointers and q_count to 0; RegWrite=0, WriteReg=0, WriteData=0. Reset mid-operation discards all queued entries; no write is issued while rst=1 or on the first edge after release.
- Handshake: a request transfers on a posedge where valid && ready. Producers hold reg/data stable while valid && !ready.
- pop = (q_count != 0). Evaluated every cycle; never blocked.
- free = DEPTH - q_count + pop.
- pri_ready = (free >= 1).
- sec_ready = pri_valid ? (free >= 2) : (free >= 1). The primary always has priority.
- Ordering: when both transfer in the same cycle, the primary entry is enqueued first (older), then the secondary.
- Register 0: an accepted request with reg == 0 completes the handshake but is not enqueued. It never produces RegWrite=1 and never counts toward q_count.
- Issue, each posedge:
  - if pop: RegWrite<=1, WriteReg<=head.reg, WriteData<=head.data; head advances.
  - else: RegWrite<=0; WriteReg and WriteData hold their previous values.
- The register file captures the write on the following negedge.
- Latency: a request accepted at edge k into an empty queue drives RegWrite=1 during the cycle after edge k+1. Sustained throughput is one write per cycle.
- Occupancy: q_count next = q_count + enq_count - pop, where enq_count ∈ {0,1,2} after register-0 filtering. It can never exceed DEPTH by construction. Pointers wrap modulo DEPTH.
- Hazard:
  - pend1 = (chk_reg1 != 0) && (any valid queue entry has reg == chk_reg1, or (RegWrite && WriteReg == chk_reg1)). pend2 is the same for chk_reg2.
  - Combinational from state only. Same-cycle incoming requests are not included.
- Simultaneous: full queue with pop → one slot is freed, so pri_ready=1. Both producers valid with free==1 → only the primary is accepted.
- Duplicate destinations are all issued in order; no coalescing.

Optional Feature:
- Macro: RF_WRITE_QUEUE_FWD_EN.
- Defined: adds outputs fwd1_data and fwd2_data (DATA_W each).
  - Each carries the youngest pending value for chk_reg1/chk_reg2.
  - Search order: queue entries youngest-first, then the issue register.
  - Output is 0 when the matching pend is 0.
- Undefined: these ports and their compare/select logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, rst pulsed high mid-cycle → RegWrite=0, WriteReg=0, WriteData=0, q_count=0, empty=1 immediately (asynchronous).
- Single write: pri reg=5 data=0xDEADBEEF at edge k, queue empty → RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in the cycle after edge k+1, then RegWrite=0; pend1=1 for chk_reg1=5 until the issue cycle ends.
- Dual accept: pri (reg=3, 0x11) and sec (reg=4, 0x22) in the same cycle, queue empty → both ready=1; issued in consecutive cycles, reg 3 first, then reg 4.
- Back-pressure: producers stalled until q_count=4, then pri and sec both valid → pri_ready=1 (pop frees one slot), sec_ready=0; sec is accepted the next cycle; no entry lost or reordered over 8 writes.
- Register 0: pri reg=0 data=0xFFFFFFFF → pri_ready=1, q_count unchanged, no RegWrite pulse, and pend1=0 for chk_reg1=0.
- With RF_WRITE_QUEUE_FWD_EN: queue holds reg 7 = 0xA then reg 7 = 0xB → pend1=1 and fwd1_data=0xB for chk_reg1=7; after both issue, pend1=0 and fwd1_data=0.
